// File: rtl/rgmii_pkg.sv
// Shared types and helpers for the RGMII transmit sequencer.
package rgmii_pkg;

    typedef enum logic [1:0] {
        SPEED_10M  = 2'b00,
        SPEED_100M = 2'b01,
        SPEED_1G   = 2'b10
    } speed_e;

    typedef struct packed {
        logic       er;
        logic       en;
        logic [7:0] d;
    } gmii_byte_t;

    localparam logic [1:0] PAT_1G = 2'b01;

    // Both 2'b10 and 2'b11 request 1000M; fold them onto one encoding.
    function automatic speed_e norm_speed(input logic [1:0] s);
        speed_e r;
        if (s[1])
            r = SPEED_1G;
        else if (s[0])
            r = SPEED_100M;
        else
            r = SPEED_10M;
        return r;
    endfunction

    function automatic int unsigned ceil_half(input int unsigned p);
        return (p + 1) / 2;
    endfunction

endpackage

// File: rtl/rgmii_tx_period_cnt.sv
// RGMII clock period counter: tracks position within a period and the nibble
// phase within a byte slot, and exposes the next-cycle level/phase for output regs.
module rgmii_tx_period_cnt
    import rgmii_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W:0]   period,
    input  logic             restart,
    output logic             slot_end,
    output logic             phase_nxt,
    output logic             level_nxt
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             phase;
    logic             period_end;

    assign period_end = ({1'b0, cnt} == (period - 1'b1));
    assign slot_end   = period_end && phase;

    always_comb begin
        cnt_nxt   = cnt + 1'b1;
        phase_nxt = phase;
        if (restart) begin
            cnt_nxt   = '0;
            phase_nxt = 1'b0;
        end else if (period_end) begin
            cnt_nxt   = '0;
            phase_nxt = ~phase;
        end
    end

    // Low for the first ceil(P/2) cycles so odd periods never shorten the low half.
    assign level_nxt = (32'(cnt_nxt) >= ceil_half(32'(period)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/rgmii_tx_rate_seq.sv
// RGMII transmit sequencer: turns GMII bytes into ODDR data/ctl/clock patterns
// at 10/100/1000M, switching speed only on byte-slot boundaries.
module rgmii_tx_rate_seq
    import rgmii_pkg::*;
#(
    parameter int DIV_10M  = 50,
    parameter int DIV_100M = 5,
    parameter int CNT_W    = $clog2(DIV_10M)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed_i,
    input  logic [7:0] mac_txd_i,
    input  logic       mac_tx_en_i,
    input  logic       mac_tx_er_i,
    output logic       mac_tx_clk_en_o,
    output logic [1:0] tx_clk_pat_o,
    output logic [3:0] txd_d1_o,
    output logic [3:0] txd_d2_o,
    output logic       tx_ctl_d1_o,
    output logic       tx_ctl_d2_o,
    output logic [1:0] speed_active_o,
    output logic       speed_busy_o
);

    localparam logic [CNT_W:0] P_10M  = DIV_10M[CNT_W:0];
    localparam logic [CNT_W:0] P_100M = DIV_100M[CNT_W:0];

    speed_e     active_q, req_q, active_n, spd_req;
    logic       first_q;
    gmii_byte_t byte_q, byte_n;
    logic [3:0] nib;
    logic       strobe, restart;
    logic       slot_end, phase_nxt, level_nxt;
    logic [CNT_W:0] period;

    logic [1:0] pat_q;
    logic [3:0] d1_q, d2_q;
    logic       ctl1_q, ctl2_q;

    assign period = (active_q == SPEED_10M) ? P_10M : P_100M;

    rgmii_tx_period_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .period    (period),
        .restart   (restart),
        .slot_end  (slot_end),
        .phase_nxt (phase_nxt),
        .level_nxt (level_nxt)
    );

    // Byte handshake: when mac_tx_clk_en_o is high the MAC byte on
    // mac_txd_i/en/er is taken at the coming edge and the MAC must advance.
    assign strobe = !first_q && ((active_q == SPEED_1G) || slot_end);

    always_comb begin
        spd_req  = norm_speed(speed_i);
        active_n = active_q;
        if (first_q) begin
            active_n = spd_req;
        end else if (active_q == SPEED_1G) begin
            // Needs the mismatch on two consecutive samples, so a one-cycle blip is dropped.
            if ((req_q != active_q) && (spd_req != active_q))
                active_n = spd_req;
        end else if (slot_end && (spd_req != active_q)) begin
            active_n = spd_req;
        end

        restart = first_q || (active_n != active_q) || (active_n == SPEED_1G);

        if (first_q)
            byte_n = '0;
        else if (strobe)
            byte_n = '{er: mac_tx_er_i, en: mac_tx_en_i, d: mac_txd_i};
        else
            byte_n = byte_q;

        nib = phase_nxt ? byte_n.d[7:4] : byte_n.d[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q  <= 1'b1;
            active_q <= SPEED_1G;
            req_q    <= SPEED_1G;
            byte_q   <= '0;
            pat_q    <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            ctl1_q   <= 1'b0;
            ctl2_q   <= 1'b0;
        end else begin
            first_q  <= 1'b0;
            active_q <= active_n;
            req_q    <= spd_req;
            byte_q   <= byte_n;
            if (active_n == SPEED_1G) begin
                pat_q  <= PAT_1G;
                d1_q   <= byte_n.d[3:0];
                d2_q   <= byte_n.d[7:4];
                ctl1_q <= byte_n.en;
                ctl2_q <= byte_n.en ^ byte_n.er;
            end else begin
                pat_q  <= {2{level_nxt}};
                d1_q   <= nib;
                d2_q   <= nib;
                ctl1_q <= level_nxt ? byte_n.en : (byte_n.en ^ byte_n.er);
                ctl2_q <= level_nxt ? byte_n.en : (byte_n.en ^ byte_n.er);
            end
        end
    end

    assign mac_tx_clk_en_o = strobe;
    assign tx_clk_pat_o    = pat_q;
    assign txd_d1_o        = d1_q;
    assign txd_d2_o        = d2_q;
    assign tx_ctl_d1_o     = ctl1_q;
    assign tx_ctl_d2_o     = ctl2_q;
    assign speed_active_o  = active_q;
    assign speed_busy_o    = (req_q != active_q);

endmodule

// File: tb/tb_rgmii_tx_rate_seq.sv
// Directed bench for rgmii_tx_rate_seq: 1000M, 100M, 10M, speed changes and reset mid-byte.
module tb_rgmii_tx_rate_seq;

    logic       clk;
    logic       rst_n;
    logic [1:0] speed_i;
    logic [7:0] mac_txd_i;
    logic       mac_tx_en_i;
    logic       mac_tx_er_i;
    logic       mac_tx_clk_en_o;
    logic [1:0] tx_clk_pat_o;
    logic [3:0] txd_d1_o;
    logic [3:0] txd_d2_o;
    logic       tx_ctl_d1_o;
    logic       tx_ctl_d2_o;
    logic [1:0] speed_active_o;
    logic       speed_busy_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    rgmii_tx_rate_seq #(.DIV_10M(50), .DIV_100M(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .speed_i         (speed_i),
        .mac_txd_i       (mac_txd_i),
        .mac_tx_en_i     (mac_tx_en_i),
        .mac_tx_er_i     (mac_tx_er_i),
        .mac_tx_clk_en_o (mac_tx_clk_en_o),
        .tx_clk_pat_o    (tx_clk_pat_o),
        .txd_d1_o        (txd_d1_o),
        .txd_d2_o        (txd_d2_o),
        .tx_ctl_d1_o     (tx_ctl_d1_o),
        .tx_ctl_d2_o     (tx_ctl_d2_o),
        .speed_active_o  (speed_active_o),
        .speed_busy_o    (speed_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_byte(input logic [7:0] d, input logic en, input logic er);
        mac_txd_i   = d;
        mac_tx_en_i = en;
        mac_tx_er_i = er;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobe"}, 8'(mac_tx_clk_en_o), 8'h0);
        chk({tag, "_pat"},    8'(tx_clk_pat_o),    8'h0);
        chk({tag, "_d1"},     8'(txd_d1_o),        8'h0);
        chk({tag, "_d2"},     8'(txd_d2_o),        8'h0);
        chk({tag, "_ctl1"},   8'(tx_ctl_d1_o),     8'h0);
        chk({tag, "_ctl2"},   8'(tx_ctl_d2_o),     8'h0);
        chk({tag, "_active"}, 8'(speed_active_o),  8'h2);
        chk({tag, "_busy"},   8'(speed_busy_o),    8'h0);
    endtask

    initial begin
        logic [7:0] exp_b;
        int         c;
        int         ph;

        // Reset state
        rst_n   = 1'b0;
        speed_i = 2'b10;
        set_byte(8'h00, 1'b0, 1'b0);
        step(2);
        chk_all_zero("reset");

        // 1000M: first edge adopts speed, byte register starts empty
        rst_n = 1'b1;
        set_byte(8'h55, 1'b1, 1'b0);
        step(1);
        chk("g_first_d1",  8'(txd_d1_o),        8'h0);
        chk("g_first_pat", 8'(tx_clk_pat_o),    8'h1);
        chk("g_strobe0",   8'(mac_tx_clk_en_o), 8'h1);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'hA5);
        step(1);
        for (int b = 0; b < 3; b++) begin
            exp_b = exp_q.pop_front();
            chk("g_d1",     8'(txd_d1_o),        8'(exp_b[3:0]));
            chk("g_d2",     8'(txd_d2_o),        8'(exp_b[7:4]));
            chk("g_ctl",    8'({tx_ctl_d2_o, tx_ctl_d1_o}), 8'h3);
            chk("g_strobe", 8'(mac_tx_clk_en_o), 8'h1);
            chk("g_pat",    8'(tx_clk_pat_o),    8'h1);
            if (b == 0) set_byte(8'hD5, 1'b1, 1'b0);
            if (b == 1) set_byte(8'hA5, 1'b1, 1'b0);
            if (b < 2) step(1);
        end

        // 1000M -> 100M reversed after one cycle: busy pulse, no adoption
        speed_i = 2'b01;
        step(1);
        chk("blip_busy",   8'(speed_busy_o),   8'h1);
        chk("blip_active", 8'(speed_active_o), 8'h2);
        speed_i = 2'b10;
        step(1);
        chk("blip_busy_clr",   8'(speed_busy_o),   8'h0);
        chk("blip_active_clr", 8'(speed_active_o), 8'h2);
        step(1);
        chk("blip_active_hold", 8'(speed_active_o), 8'h2);
        chk("blip_d1",          8'(txd_d1_o),       8'h5);
        chk("blip_d2",          8'(txd_d2_o),       8'hA);

        // 1000M -> 100M: byte A5 strobed at the adoption edge is sent at 100M
        speed_i = 2'b01;
        step(1);
        chk("g2f_busy", 8'(speed_busy_o), 8'h1);
        step(1);
        chk("f_active", 8'(speed_active_o),  8'h1);
        chk("f_busy",   8'(speed_busy_o),    8'h0);
        chk("f_pat0",   8'(tx_clk_pat_o),    8'h0);
        chk("f_d1_0",   8'(txd_d1_o),        8'h5);
        chk("f_d2_0",   8'(txd_d2_o),        8'h5);
        chk("f_ctl_0",  8'(tx_ctl_d1_o),     8'h1);
        chk("f_strb_0", 8'(mac_tx_clk_en_o), 8'h0);
        set_byte(8'h3C, 1'b1, 1'b0);
        for (int i = 1; i < 10; i++) begin
            step(1);
            c  = i % 5;
            ph = i / 5;
            chk("f_pat",    8'(tx_clk_pat_o),    (c >= 3) ? 8'h3 : 8'h0);
            chk("f_d1",     8'(txd_d1_o),        (ph == 1) ? 8'hA : 8'h5);
            chk("f_d2",     8'(txd_d2_o),        (ph == 1) ? 8'hA : 8'h5);
            chk("f_strobe", 8'(mac_tx_clk_en_o), (i == 9) ? 8'h1 : 8'h0);
        end
        step(1);
        chk("f2_d1",     8'(txd_d1_o),        8'hC);
        chk("f2_strobe", 8'(mac_tx_clk_en_o), 8'h0);
        step(1);

        // 100M -> 10M requested at phase 0 cnt 1
        speed_i = 2'b00;
        step(1);
        chk("f2t_busy",   8'(speed_busy_o),   8'h1);
        chk("f2t_active", 8'(speed_active_o), 8'h1);
        set_byte(8'h96, 1'b1, 1'b1);
        for (int j = 3; j < 10; j++) begin
            step(1);
            chk("f2t_busy_hold", 8'(speed_busy_o),    8'h1);
            chk("f2t_strobe",    8'(mac_tx_clk_en_o), (j == 9) ? 8'h1 : 8'h0);
            chk("f2t_pat",       8'(tx_clk_pat_o),    ((j % 5) >= 3) ? 8'h3 : 8'h0);
        end
        step(1);
        chk("t_active", 8'(speed_active_o), 8'h0);
        chk("t_busy",   8'(speed_busy_o),   8'h0);
        chk("t_pat0",   8'(tx_clk_pat_o),   8'h0);
        chk("t_d1_0",   8'(txd_d1_o),       8'h6);
        chk("t_ctl_0",  8'(tx_ctl_d1_o),    8'h0);
        set_byte(8'h12, 1'b1, 1'b0);
        for (int i = 1; i < 100; i++) begin
            step(1);
            c  = i % 50;
            ph = i / 50;
            chk("t_pat",    8'(tx_clk_pat_o),    (c >= 25) ? 8'h3 : 8'h0);
            chk("t_d1",     8'(txd_d1_o),        (ph == 1) ? 8'h9 : 8'h6);
            chk("t_ctl",    8'({tx_ctl_d2_o, tx_ctl_d1_o}), (c >= 25) ? 8'h3 : 8'h0);
            chk("t_strobe", 8'(mac_tx_clk_en_o), (i == 99) ? 8'h1 : 8'h0);
        end
        step(1);
        chk("t2_d1",  8'(txd_d1_o),    8'h2);
        chk("t2_ctl", 8'(tx_ctl_d1_o), 8'h1);
        chk("t2_pat", 8'(tx_clk_pat_o), 8'h0);
        step(10);

        // Reset mid-byte at 10M, then release into 100M
        rst_n   = 1'b0;
        speed_i = 2'b01;
        step(1);
        chk_all_zero("midrst");
        rst_n = 1'b1;
        step(1);
        chk("rel_active", 8'(speed_active_o), 8'h1);
        chk("rel_busy",   8'(speed_busy_o),   8'h0);
        chk("rel_pat",    8'(tx_clk_pat_o),   8'h0);
        chk("rel_d1",     8'(txd_d1_o),       8'h0);
        chk("rel_ctl",    8'(tx_ctl_d1_o),    8'h0);
        for (int i = 1; i < 10; i++) begin
            step(1);
            chk("rel_d1_idle", 8'(txd_d1_o),        8'h0);
            chk("rel_ctl_idle", 8'(tx_ctl_d1_o),    8'h0);
            chk("rel_strobe",  8'(mac_tx_clk_en_o), (i == 9) ? 8'h1 : 8'h0);
        end
        step(1);
        chk("rel2_d1",  8'(txd_d1_o),    8'h2);
        chk("rel2_ctl", 8'(tx_ctl_d1_o), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
